// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's complement of a W-bit vector (magnitude extraction and
// result sign correction).
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  // negate when requested, pass through otherwise
  always_comb begin
    if (neg) begin
      dout = (~din) + {{(W-1){1'b0}}, 1'b1};
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional MDU_EARLY_TERM_EN: multiply stops once no set multiplier bits remain.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_r;
  logic [1:0]           op_r;
  logic                 sa_r, sb_r, divz_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r, mcand_r;
  logic [WIDTH-1:0]     opb_r;
  logic                 busy_r, done_r, dz_r;
  logic [WIDTH-1:0]     hi_r, lo_r;

  logic                 a_neg_s, b_neg_s;
  logic [WIDTH-1:0]     amag_s, bmag_s;
  logic [WIDTH:0]       rem_sh_s, diff_s;
  logic [2*WIDTH-1:0]   acc_next_s, prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;
  logic                 last_s;
  logic                 prod_neg_s, quo_neg_s, rem_neg_s;

  assign a_neg_s    = ~op[0] & a[WIDTH-1];
  assign b_neg_s    = ~op[0] & b[WIDTH-1];
  assign prod_neg_s = (op_r == OP_MULT) & (sa_r ^ sb_r);
  assign quo_neg_s  = (op_r == OP_DIV) & (sa_r ^ sb_r);
  assign rem_neg_s  = (op_r == OP_DIV) & sa_r;

  mdu_sign_fix #(.W(WIDTH))   u_amag (.din(a), .neg(a_neg_s), .dout(amag_s));
  mdu_sign_fix #(.W(WIDTH))   u_bmag (.din(b), .neg(b_neg_s), .dout(bmag_s));
  mdu_sign_fix #(.W(2*WIDTH)) u_prod (.din(acc_r), .neg(prod_neg_s), .dout(prod_s));
  mdu_sign_fix #(.W(WIDTH))   u_quo  (.din(acc_r[WIDTH-1:0]), .neg(quo_neg_s), .dout(quo_s));
  mdu_sign_fix #(.W(WIDTH))   u_rem  (.din(acc_r[2*WIDTH-1:WIDTH]), .neg(rem_neg_s), .dout(rem_s));

  // one radix-2 step: acc = {remainder, dividend/quotient} for divide, product for multiply
  always_comb begin
    rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s     = rem_sh_s - {1'b0, opb_r};
    acc_next_s = acc_r;
    if (op_r[1]) begin
      if (diff_s[WIDTH]) begin
        acc_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (opb_r[0]) begin
        acc_next_s = acc_r + mcand_r;
      end else begin
        acc_next_s = acc_r;
      end
    end
  end

  // decide whether the current iteration is the final one
  always_comb begin
    last_s = (cnt_r == CNT_LAST);
`ifdef MDU_EARLY_TERM_EN
    if (!op_r[1] && (opb_r[WIDTH-1:1] == {(WIDTH-1){1'b0}})) begin
      last_s = 1'b1;
    end else begin
      last_s = (cnt_r == CNT_LAST);
    end
`endif
  end

  // control FSM, datapath registers and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_r    <= OP_MULT;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      divz_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {(2*WIDTH){1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            sa_r    <= a_neg_s;
            sb_r    <= b_neg_s;
            divz_r  <= op[1] & (b == {WIDTH{1'b0}});
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= op[1] ? {{WIDTH{1'b0}}, amag_s} : {(2*WIDTH){1'b0}};
            mcand_r <= {{WIDTH{1'b0}}, amag_s};
            opb_r   <= bmag_s;
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            // register moves only when no operation is being launched
            if (mthi) hi_r <= wdata;
            if (mtlo) lo_r <= wdata;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (!op_r[1]) begin
            mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
            opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
          end
          if (last_s) state_r <= FIX;
        end
        FIX: begin
          if (op_r[1]) begin
            hi_r <= rem_s;
            lo_r <= divz_r ? {WIDTH{1'b1}} : quo_s;
            dz_r <= divz_r;
          end else begin
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_s[WIDTH-1:0];
          end
          cnt_r   <= {CNT_W{1'b0}};
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule
